// File: rtl/als_spi_responder.sv
// Ambient-light-sensor ADC emulator: answers 16-clock SPI read frames
// with {4'b0, sample, 4'b0}, MSB first, on ALS_SDO.
module als_spi_responder #(
  parameter int          SYNC_STAGES  = 2,
  parameter logic [7:0]  RESET_SAMPLE = 8'd0,
  parameter int          FRAME_BITS   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sample,
  input  logic       sample_valid,
  input  logic       ALS_CS,
  input  logic       ALS_SCK,
  output logic       ALS_SDO,
  output logic       sdo_oe,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_abort
);

  typedef enum logic [1:0] {IDLE, SHIFT, TAIL} state_t;

  localparam logic [4:0] LAST = 5'(FRAME_BITS);

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sck_sync;
  logic       cs_prev;
  logic       sck_prev;
  logic       cs_s;
  logic       sck_s;
  logic       cs_fall;
  logic       cs_rise;
  logic       sck_fall;
  logic       sck_rise;
  state_t     state;
  state_t     state_n;
  logic [7:0] hold;
  logic [15:0] shift;
  logic [15:0] shift_n;
  logic [4:0] cnt;
  logic [4:0] cnt_n;
  logic       sdo_n;
  logic       oe_n;
  logic       busy_n;
  logic       done_n;
  logic       abort_n;

  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_fall  = cs_prev & ~cs_s;
  assign cs_rise  = ~cs_prev & cs_s;
  assign sck_fall = sck_prev & ~sck_s;
  assign sck_rise = ~sck_prev & sck_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_sync     <= '1;
      sck_sync    <= '1;
      cs_prev     <= 1'b1;
      sck_prev    <= 1'b1;
      hold        <= RESET_SAMPLE;
      state       <= IDLE;
      shift       <= '0;
      cnt         <= '0;
      ALS_SDO     <= 1'b0;
      sdo_oe      <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      cs_sync     <= {cs_sync[SYNC_STAGES-2:0], ALS_CS};
      sck_sync    <= {sck_sync[SYNC_STAGES-2:0], ALS_SCK};
      cs_prev     <= cs_s;
      sck_prev    <= sck_s;
      if (sample_valid)
        hold <= sample;
      state       <= state_n;
      shift       <= shift_n;
      cnt         <= cnt_n;
      ALS_SDO     <= sdo_n;
      sdo_oe      <= oe_n;
      busy        <= busy_n;
      frame_done  <= done_n;
      frame_abort <= abort_n;
    end
  end

  always_comb begin
    state_n = state;
    shift_n = shift;
    cnt_n   = cnt;
    sdo_n   = ALS_SDO;
    oe_n    = sdo_oe;
    busy_n  = busy;
    done_n  = 1'b0;
    abort_n = 1'b0;
    unique case (state)
      IDLE: begin
        sdo_n = 1'b0;
        oe_n  = 1'b0;
        if (cs_fall) begin
          state_n = SHIFT;
          shift_n = {4'b0, hold, 4'b0};
          cnt_n   = '0;
          sdo_n   = shift_n[15];
          oe_n    = 1'b1;
          busy_n  = 1'b1;
        end
      end
      SHIFT, TAIL: begin
        if (cs_rise) begin
          state_n = IDLE;
          sdo_n   = 1'b0;
          oe_n    = 1'b0;
          busy_n  = 1'b0;
          done_n  = (cnt == LAST);
          abort_n = (cnt != LAST);
        end else if (state == TAIL) begin
          sdo_n = 1'b0;
        end else if (sck_rise) begin
          cnt_n = cnt + 5'd1;
          if (cnt_n == LAST) begin
            state_n = TAIL;
            sdo_n   = 1'b0;
          end
        end else if (sck_fall && cnt != '0) begin
          // falls before the first rise are CS-while-SCK-high artefacts
          shift_n = {shift[14:0], 1'b0};
          sdo_n   = shift_n[15];
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_als_spi_responder.sv
// Bench for als_spi_responder: table of directed frames, a reset-in-frame
// sequence and randomized frames against a word-level reader model.
module tb_als_spi_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sample;
  logic       sample_valid;
  logic       ALS_CS;
  logic       ALS_SCK;
  logic       ALS_SDO;
  logic       sdo_oe;
  logic       busy;
  logic       frame_done;
  logic       frame_abort;

  int ncmp = 0;
  int nerr = 0;
  int ndone = 0;
  int nabort = 0;
  logic [7:0] hold_m;

  als_spi_responder dut (
    .clk(clk), .reset(reset), .sample(sample),
    .sample_valid(sample_valid), .ALS_CS(ALS_CS),
    .ALS_SCK(ALS_SCK), .ALS_SDO(ALS_SDO), .sdo_oe(sdo_oe),
    .busy(busy), .frame_done(frame_done),
    .frame_abort(frame_abort)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done) ndone++;
    if (frame_abort) nabort++;
  end

  typedef struct {
    bit          ld;
    logic [7:0]  smp;
    int          n;
    bit          hi;
    int          mid;
    logic [7:0]  mv;
    logic [31:0] exp_rx;
    int          exp_done;
    int          exp_abort;
  } vec_t;

  vec_t tbl[9];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic load(input logic [7:0] v);
    sample = v;
    sample_valid = 1'b1;
    tick(1);
    sample_valid = 1'b0;
  endtask

  task automatic run_frame(input int n, input int half, input bit hi,
                           input int mid, input logic [7:0] mv,
                           output logic [31:0] rx,
                           output logic [1:0] act_mid,
                           output logic [1:0] act_end);
    rx = '0;
    ALS_SCK = hi;
    tick(6);
    ALS_CS = 1'b0;
    tick(half + 2);
    if (hi) begin
      ALS_SCK = 1'b0;
      tick(half);
    end
    for (int i = 0; i < n; i++) begin
      rx = {rx[30:0], ALS_SDO};
      ALS_SCK = 1'b1;
      if (i == mid) begin
        load(mv);
        tick(half - 1);
      end else begin
        tick(half);
      end
      ALS_SCK = 1'b0;
      tick(half);
    end
    act_mid = {busy, sdo_oe};
    ALS_CS = 1'b1;
    tick(6);
    act_end = {busy, sdo_oe};
  endtask

  task automatic check_frame(input string tag, input int n,
                             input int half, input bit hi,
                             input int mid, input logic [7:0] mv,
                             input logic [31:0] exp_rx,
                             input int exp_done, input int exp_abort);
    logic [31:0] rx;
    logic [1:0]  am;
    logic [1:0]  ae;
    int d0;
    int a0;
    d0 = ndone;
    a0 = nabort;
    run_frame(n, half, hi, mid, mv, rx, am, ae);
    chk({tag, " rx"}, rx, exp_rx);
    chk({tag, " done"}, 32'(ndone - d0), 32'(exp_done));
    chk({tag, " abort"}, 32'(nabort - a0), 32'(exp_abort));
    chk({tag, " busy/oe in frame"}, 32'(am), 32'h3);
    chk({tag, " busy/oe after"}, 32'(ae), 32'h0);
  endtask

  function automatic logic [31:0] model_rx(input logic [7:0] h,
                                           input int n);
    logic [15:0] word;
    logic [31:0] r;
    word = {4'b0, h, 4'b0};
    r = '0;
    for (int i = 0; i < n; i++)
      r = {r[30:0], (i < 16) ? word[15 - i] : 1'b0};
    return r;
  endfunction

  initial begin
    tbl[0] = '{1, 8'hA5, 16, 0, -1, 8'h00, 32'h0A50, 1, 0};
    tbl[1] = '{0, 8'h00, 16, 1, -1, 8'h00, 32'h0A50, 1, 0};
    tbl[2] = '{1, 8'h3C, 16, 0, 5, 8'hFF, 32'h03C0, 1, 0};
    tbl[3] = '{0, 8'h00, 16, 0, -1, 8'h00, 32'h0FF0, 1, 0};
    tbl[4] = '{1, 8'h5A, 9, 0, -1, 8'h00, 32'h000B, 0, 1};
    tbl[5] = '{0, 8'h00, 16, 0, -1, 8'h00, 32'h05A0, 1, 0};
    tbl[6] = '{1, 8'hC3, 20, 1, -1, 8'h00, 32'hC300, 1, 0};
    tbl[7] = '{1, 8'h81, 0, 0, -1, 8'h00, 32'h0000, 0, 1};
    tbl[8] = '{0, 8'h00, 16, 0, -1, 8'h00, 32'h0810, 1, 0};

    reset = 1'b1;
    sample = 8'h00;
    sample_valid = 1'b0;
    ALS_CS = 1'b1;
    ALS_SCK = 1'b0;
    hold_m = 8'h00;
    tick(3);
    chk("reset outputs",
        {27'b0, ALS_SDO, sdo_oe, busy, frame_done, frame_abort}, 0);
    reset = 1'b0;
    tick(6);
    chk("idle outputs",
        {27'b0, ALS_SDO, sdo_oe, busy, frame_done, frame_abort}, 0);

    for (int r = 0; r < 9; r++) begin
      if (tbl[r].ld) begin
        load(tbl[r].smp);
        hold_m = tbl[r].smp;
      end
      check_frame($sformatf("row%0d", r), tbl[r].n, 4, tbl[r].hi,
                  tbl[r].mid, tbl[r].mv, tbl[r].exp_rx,
                  tbl[r].exp_done, tbl[r].exp_abort);
      if (tbl[r].mid >= 0 && tbl[r].mid < tbl[r].n)
        hold_m = tbl[r].mv;
    end

    begin
      int d0;
      int a0;
      load(8'h77);
      d0 = ndone;
      a0 = nabort;
      ALS_CS = 1'b0;
      tick(6);
      for (int i = 0; i < 8; i++) begin
        ALS_SCK = 1'b1;
        tick(4);
        ALS_SCK = 1'b0;
        tick(4);
      end
      ALS_SCK = 1'b1;
      tick(2);
      chk("mid-frame busy/oe", {30'b0, busy, sdo_oe}, 32'h3);
      reset = 1'b1;
      #1;
      chk("async reset outputs", {29'b0, ALS_SDO, sdo_oe, busy}, 0);
      tick(2);
      ALS_CS = 1'b1;
      ALS_SCK = 1'b0;
      tick(2);
      reset = 1'b0;
      tick(8);
      chk("reset no done", 32'(ndone - d0), 0);
      chk("reset no abort", 32'(nabort - a0), 0);
      hold_m = 8'h00;
      check_frame("post-reset", 16, 4, 0, -1, 8'h00,
                  32'h0000, 1, 0);
    end

    for (int k = 0; k < 30; k++) begin
      int n;
      int half;
      int mid;
      bit hi;
      logic [7:0] mv;
      logic [31:0] exp_rx;
      if ($urandom_range(0, 1) == 1) begin
        mv = 8'($urandom);
        load(mv);
        hold_m = mv;
      end
      n = $urandom_range(0, 20);
      half = $urandom_range(4, 7);
      hi = 1'($urandom_range(0, 1));
      mv = 8'($urandom);
      mid = (n > 0 && $urandom_range(0, 2) == 0) ?
            $urandom_range(0, n - 1) : -1;
      exp_rx = model_rx(hold_m, n);
      check_frame($sformatf("rand%0d", k), n, half, hi, mid, mv,
                  exp_rx, (n >= 16) ? 1 : 0, (n >= 16) ? 0 : 1);
      if (mid >= 0)
        hold_m = mv;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
